// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target.
//   i2c_state_t       - transaction FSM states
//   I2C_BITS_PER_BYTE - bits shifted per byte on the bus
//   SYNC_STAGES       - depth of the SCL/SDA metastability synchroniser
//   addr_match()      - compares the 7-bit address field of a received address byte
package i2c_pkg;

  localparam int I2C_BITS_PER_BYTE = 8;
  localparam int SYNC_STAGES       = 2;

  // Value of the 3-bit bit counter on the last bit of a byte.
  localparam logic [2:0] LAST_BIT = 3'(I2C_BITS_PER_BYTE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  // The address byte carries the address in bits [7:1] and R/W in bit 0.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings the asynchronous SCL/SDA pins into the clk domain and
// detects bus events.
//   clk, reset           - system clock, synchronous active-high reset
//   scl_in, sda_in       - raw bus levels (asynchronous)
//   scl_level, sda_level - synchronised levels, aligned with the event pulses
//   scl_rise, scl_fall   - one-cycle SCL edge pulses
//   start_det, stop_det  - one-cycle START / STOP condition pulses
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_level,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_pipe[SYNC_STAGES-1];
  assign sda_now = sda_pipe[SYNC_STAGES-1];

  // The history flops double as the level outputs, so a level read in the
  // same cycle as an event pulse is the post-edge value. Everything resets to
  // the idle bus state (both lines high) so reset itself creates no START.
  // START/STOP require SCL high in both the current and previous samples so a
  // simultaneous SCL edge is never mistaken for a condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_pipe  <= '1;
      sda_pipe  <= '1;
      scl_level <= 1'b1;
      sda_level <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_pipe  <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
      sda_pipe  <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
      scl_level <= scl_now;
      sda_level <= sda_now;
      scl_rise  <= scl_now & ~scl_level;
      scl_fall  <= ~scl_now & scl_level;
      start_det <= ~sda_now & sda_level & scl_now & scl_level;
      stop_det  <= sda_now & ~sda_level & scl_now & scl_level;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit-address I2C target with byte-wide user interface.
//   clk, reset - 50 MHz system clock, synchronous active-high reset
//   scl_in     - bus SCL level (never driven; no clock stretching)
//   sda_in     - bus SDA level
//   sda_out    - open-drain SDA drive: 1 = release, 0 = pull low
//   tx_data    - byte returned to the master on reads
//   tx_load    - one-cycle pulse when tx_data is latched for transmission
//   rx_data    - last byte written by the master
//   rx_valid   - one-cycle pulse when rx_data updates
//   busy       - high whenever the FSM is outside IDLE
//   rw         - R/W bit of the most recent matching address (1 = read)
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       rw
);

  logic       scl_level;
  logic       sda_level;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bit_rise;

  i2c_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] shifted;
  logic       ack_phase;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_level (scl_level),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign bit_rise = scl_rise & scl_level;
  assign shifted  = {shift_reg[6:0], sda_level};
  assign busy     = (state != IDLE);

  // ack_phase splits each ACK slot into two SCL falls: the first fall starts
  // the slot (ADDR_ACK/WR_ACK drive low), the second ends it. In RD_ACK it
  // records that the master ACKed on the rise, so the next fall reloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ack_phase <= 1'b0;
      sda_out   <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      rw        <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_out   <= 1'b1;
      end else if (stop_det) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_out   <= 1'b1;
      end else begin
        unique case (state)
          IDLE, WAIT_STOP: sda_out <= 1'b1;

          ADDR: begin
            if (bit_rise) begin
              shift_reg <= shifted;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                if (addr_match(shifted, SLAVE_ADDR)) begin
                  state <= ADDR_ACK;
                  rw    <= shifted[0];
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_out   <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (rw) begin
                  shift_reg <= tx_data;
                  sda_out   <= tx_data[7];
                  tx_load   <= 1'b1;
                  state     <= RD_DATA;
                end else begin
                  sda_out <= 1'b1;
                  state   <= WR_DATA;
                end
              end
            end
          end

          WR_DATA: begin
            if (bit_rise) begin
              shift_reg <= shifted;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                rx_data   <= shifted;
                rx_valid  <= 1'b1;
                ack_phase <= 1'b0;
                state     <= WR_ACK;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_out   <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                sda_out   <= 1'b1;
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                state     <= WR_DATA;
              end
            end
          end

          // The MSB is already on the bus on entry; each fall presents the
          // next bit, and the fall after the 8th bit releases for the ACK.
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == LAST_BIT) begin
                sda_out   <= 1'b1;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                state     <= RD_ACK;
              end else begin
                sda_out   <= shift_reg[6];
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
              end
            end
          end

          RD_ACK: begin
            if (bit_rise) begin
              if (sda_level) state <= WAIT_STOP;
              else           ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              shift_reg <= tx_data;
              sda_out   <= tx_data[7];
              tx_load   <= 1'b1;
              state     <= RD_DATA;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: randomized and directed bench for i2c_slave.
// A behavioural bus master drives SCL/SDA; for every clocked bit slot it
// queues the SDA drive the target should present, and for every transaction
// the bytes it should deliver / load. Independent monitors pop and compare
// when the target presents a bit slot, an rx_valid or a tx_load pulse.
module tb_i2c_slave;

  localparam logic [6:0] SLAVE_ADDR = 7'h50;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_out;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       rw;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] load_q[$];
  bit         slot_q[$];
  bit         slot_active = 1'b0;
  logic       exp_rw = 1'b0;
  logic [7:0] xfer[4];
  logic       rx_prev = 1'b0;
  logic       ld_prev = 1'b0;

  // Open-drain wired-AND of master and target.
  assign sda_bus = sda_m & sda_out;

  always #10 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_out  (sda_out),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .rw       (rw)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bit-slot monitor: samples the target's drive mid-way through SCL high.
  initial begin
    forever begin
      @(posedge scl_m);
      if (slot_active) begin
        repeat (6) @(negedge clk);
        checkOutput("slot queued", 8'(slot_q.size() != 0), 8'd1);
        if (slot_q.size() != 0) checkOutput("sda slot", {7'd0, sda_out}, {7'd0, slot_q.pop_front()});
      end
    end
  end

  // Pulse monitor: rx_valid / tx_load must be expected, single-cycle, disjoint.
  always @(negedge clk) begin
    if (rx_valid) begin
      checkOutput("rx_valid expected", 8'(rx_q.size() != 0), 8'd1);
      if (rx_q.size() != 0) checkOutput("rx_data", rx_data, rx_q.pop_front());
      checkOutput("rx_valid width", {7'd0, rx_prev}, 8'd0);
      checkOutput("pulse overlap", {7'd0, tx_load}, 8'd0);
    end
    if (tx_load) begin
      checkOutput("tx_load expected", 8'(load_q.size() != 0), 8'd1);
      if (load_q.size() != 0) void'(load_q.pop_front());
      checkOutput("tx_load width", {7'd0, ld_prev}, 8'd0);
    end
    rx_prev = rx_valid;
    ld_prev = tx_load;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input bit b, input bit exp_slave);
    wait_clk(Q);
    sda_m = b;
    slot_q.push_back(exp_slave);
    wait_clk(Q);
    slot_active = 1'b1;
    scl_m = 1'b1;
    wait_clk(2 * Q);
    scl_m = 1'b0;
    slot_active = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(Q);
  endtask

  // Master writes a byte; the target only listens, then ACKs if addressed.
  task automatic send_byte(input logic [7:0] b, input bit acked);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b1);
    clock_bit(1'b1, !acked);
  endtask

  // One transaction from START; bytes come from xfer[0..n-1].
  task automatic applyStimulus(input logic [6:0] addr, input bit rd, input int n, input bit do_stop);
    bit matched;
    matched = (addr == SLAVE_ADDR);
    if (matched) begin
      exp_rw = rd;
      for (int k = 0; k < n; k++) begin
        if (rd) load_q.push_back(xfer[k]);
        else    rx_q.push_back(xfer[k]);
      end
      if (rd) tx_data = xfer[0];
    end
    i2c_start();
    send_byte({addr, rd}, matched);
    checkOutput("rw", {7'd0, rw}, {7'd0, exp_rw});
    checkOutput("busy in frame", {7'd0, busy}, 8'd1);
    for (int k = 0; k < n; k++) begin
      if (!rd) begin
        send_byte(xfer[k], matched);
      end else begin
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, matched ? xfer[k][i] : 1'b1);
        if (k + 1 < n) tx_data = xfer[k + 1];
        clock_bit(k == n - 1, 1'b1);
      end
    end
    if (do_stop) begin
      i2c_stop();
      wait_clk(6);
      checkOutput("busy after stop", {7'd0, busy}, 8'd0);
    end
  endtask

  initial begin
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    $display("[TB] reset values");
    checkOutput("reset sda_out", {7'd0, sda_out}, 8'd1);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset rx_valid", {7'd0, rx_valid}, 8'd0);
    checkOutput("reset tx_load", {7'd0, tx_load}, 8'd0);
    checkOutput("reset busy", {7'd0, busy}, 8'd0);
    checkOutput("reset rw", {7'd0, rw}, 8'd0);

    $display("[TB] write A5");
    xfer[0] = 8'hA5;
    applyStimulus(7'h50, 1'b0, 1, 1'b1);
    checkOutput("rx_data held", rx_data, 8'hA5);

    $display("[TB] wrong address");
    xfer[0] = 8'h5A;
    applyStimulus(7'h51, 1'b0, 1, 1'b1);

    $display("[TB] read one byte");
    xfer[0] = 8'h3C;
    applyStimulus(7'h50, 1'b1, 1, 1'b1);

    $display("[TB] read two bytes");
    xfer[0] = 8'h3C;
    xfer[1] = 8'hC3;
    applyStimulus(7'h50, 1'b1, 2, 1'b1);

    $display("[TB] write then repeated start read");
    xfer[0] = 8'h11;
    applyStimulus(7'h50, 1'b0, 1, 1'b0);
    xfer[0] = 8'h96;
    applyStimulus(7'h50, 1'b1, 1, 1'b1);
    checkOutput("rx_data after restart", rx_data, 8'h11);
    checkOutput("rw after restart", {7'd0, rw}, 8'd1);

    $display("[TB] reset mid-read");
    tx_data = 8'h3C;
    load_q.push_back(8'h3C);
    i2c_start();
    send_byte({SLAVE_ADDR, 1'b1}, 1'b1);
    clock_bit(1'b1, 1'b0);
    wait_clk(6);
    checkOutput("sda before reset", {7'd0, sda_out}, 8'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sda after reset", {7'd0, sda_out}, 8'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_rw = 1'b0;
    for (int i = 0; i < 7; i++) clock_bit(1'b1, 1'b1);
    clock_bit(1'b0, 1'b1);
    send_byte(8'h00, 1'b0);
    i2c_stop();
    wait_clk(6);
    checkOutput("busy after reset", {7'd0, busy}, 8'd0);
    xfer[0] = 8'h77;
    applyStimulus(7'h50, 1'b0, 1, 1'b1);

    $display("[TB] random transactions");
    for (int t = 0; t < 20; t++) begin
      logic [6:0] a;
      bit         rd;
      int         n;
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      rd = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) xfer[k] = 8'($urandom_range(0, 255));
      applyStimulus(a, rd, n, (t == 19) || ($urandom_range(0, 3) != 0));
    end

    wait_clk(20);
    checkOutput("rx queue drained", 8'(rx_q.size()), 8'd0);
    checkOutput("load queue drained", 8'(load_q.size()), 8'd0);
    checkOutput("slot queue drained", 8'(slot_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) that answers the team's I2C master on the same open-drain bus. It uses a single-clock oversampled design: SCL and SDA are synchronised, edges and START/STOP conditions are detected, and the block then runs a 7-bit-address transaction FSM. Write bytes are presented to user logic with a one-cycle strobe, and read bytes are fetched from user logic. At the top level it sits beside the master and uses the same open-drain convention: an internal drive bit is tri-stated to `z` when 1 and pulls low when 0.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target responds to.
- `clk` in 1: system clock (50 MHz); all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `scl_in` in 1: bus SCL level (asynchronous).
- `sda_in` in 1: bus SDA level (asynchronous).
- `sda_out` in/out role: out 1: 1 = release SDA, 0 = pull SDA low. SCL is never driven (no clock stretching).
- `tx_data` in 8: byte returned to the master on reads.
- `tx_load` out 1: one-cycle pulse when `tx_data` is latched into the shift register.
- `rx_data` out 8: last byte written by the master; held until the next byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high from START to STOP while addressed, or while in any non-IDLE state.
- `rw` out 1: R/W bit of the current addressed transaction (1 = read).

## Operation
- **Bus conditions**
  - START: SDA falls while SCL is high (synchronised levels).
  - STOP: SDA rises while SCL is high.
  - START is honoured in every state, including repeated START. It clears the bit counter and enters ADDR.
  - STOP from any state returns the FSM to IDLE and releases SDA.
- **Bit timing**
  - Data bits are sampled on the SCL rising edge, MSB first.
  - `sda_out` changes only on the SCL falling edge.
- **States**
  - IDLE: `sda_out` = 1. Waits for START.
  - ADDR: shifts in 8 bits (7 address bits plus R/W). After the 8th rise:
    - on match → ADDR_ACK, and `rw` latched;
    - on mismatch → WAIT_STOP.
  - ADDR_ACK: drives SDA low from the next SCL fall until the following fall. Then:
    - if `rw`=0 → WR_DATA;
    - if `rw`=1 → `tx_data` latched, `tx_load` pulsed, MSB driven, → RD_DATA.
  - WR_DATA: shifts in 8 bits. On the 8th rise, `rx_data` updates and `rx_valid` pulses; → WR_ACK.
  - WR_ACK: ACK is always given (SDA low for one SCL period), then → WR_DATA.
  - RD_DATA: drives shift-register bits on each fall. After the 8th bit's fall, SDA is released; → RD_ACK.
  - RD_ACK: samples SDA on the rise.
    - 0 (master ACK): on the next fall, latch `tx_data`, pulse `tx_load`, drive MSB; → RD_DATA.
    - 1 (NACK): → WAIT_STOP.
  - WAIT_STOP: SDA released. Waits for STOP (→ IDLE) or START (→ ADDR).
- **Counters and registers**
  - Bit counter is 3 bits and wraps 7→0 at each byte boundary.
  - Shift register is 8 bits.
- **Reset mid-transaction**
  - `sda_out`=1 on the cycle after `reset` is sampled; FSM goes to IDLE.
  - The current bus transfer is ignored until a new START.

## Timing
- Input path: 2-flop synchroniser plus one history flop. An edge or condition is visible 3 `clk` cycles after the pin changes.
- `sda_out` updates on the 4th cycle after the SCL falling pin edge.
  - The SCL low phase must therefore be ≥ 8 `clk` cycles; 100/400 kHz at 50 MHz satisfies this.
- `rx_valid` and `tx_load` are exactly 1 cycle wide and never asserted in the same cycle.
- Simultaneous START detection and a bit edge: START has priority.
- Reset values: `sda_out`=1, `rx_data`=8'h00, `rx_valid`=0, `tx_load`=0, `busy`=0, `rw`=0, state IDLE, counter 0.

## Structure
- Package `i2c_pkg`:
  - FSM state encoding: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - `I2C_BITS_PER_BYTE`=8, `SYNC_STAGES`=2.
- Sub-module `i2c_bus_sync`:
  - synchronises SCL and SDA;
  - outputs levels plus one-cycle `scl_rise`, `scl_fall`, `start_det`, `stop_det` pulses.
- Top FSM, shift register and counter live in `i2c_slave`.

## Test plan
- Write 0x50+W, data 0xA5, STOP → ACK on the address and data slots; `rx_data`=0xA5 with a single `rx_valid` pulse; `busy` falls after STOP.
- Address 0x51+W → `sda_out` stays 1 for the entire frame; no `rx_valid`; FSM reaches IDLE after STOP.
- Read 0x50+R with `tx_data`=0x3C, master NACK → SDA bits 0,0,1,1,1,1,0,0; one `tx_load`; SDA released in the ACK slot.
- Read two bytes (0x3C then 0xC3), master ACK then NACK → two `tx_load` pulses; second byte emitted correctly.
- Write 0x50+W, byte 0x11, repeated START 0x50+R → `rx_data`=0x11; `rw`=1; read byte driven from `tx_data`.
- `reset` asserted while driving a 0 bit mid-read → `sda_out`=1 next cycle; no ACK and no `rx_valid` until a new START.
